// File: rtl/ifu.sv
// ifu -- instruction fetch unit.
//
// Fetches instruction bytes over a shared memory bus into a small FIFO and
// presents the FIFO head to the controller. Reads run one at a time through
// a two-state FSM (IDLE/REQ). The controller's data accesses take the bus
// whenever the FSM is idle. A redirect (pc_load) flushes the FIFO and moves
// the fetch PC. If a read is in flight at that moment, its byte is dropped
// when it returns.
//
// Build option: define IFU_PREFETCH_EN for a 2-entry buffer, so fetch keeps
// running while one instruction waits. Left undefined, the buffer has 1 entry
// and a read starts only once the buffer is empty or being popped.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   mem_addr, mem_rd      instruction read request (held until mem_ready)
//   mem_ready, mem_rdata  read completion and returned byte
//   data_req, bus_gnt     controller data-access request / grant
//   pc_load, pc_target    redirect request and target address
//   instr, instr_valid    FIFO head to the controller (opcode [7:4], operand [3:0])
//   instr_ready           controller accepts instr this cycle
module ifu #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata,
    input  logic        data_req,
    output logic        bus_gnt,
    input  logic        pc_load,
    input  logic [15:0] pc_target,
    output logic [7:0]  instr,
    output logic        instr_valid,
    input  logic        instr_ready
);

`ifdef IFU_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [15:0]      pc;
    logic [15:0]      req_addr;
    logic             discard;
    logic [7:0]       fifo [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;

    logic rd_done, push, pop, can_fetch;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A redirect beats any same-cycle push or pop.
    assign rd_done   = (state == REQ) && mem_ready;
    assign push      = rd_done && !discard && !pc_load;
    assign pop       = instr_valid && instr_ready && !pc_load;
    // A slot freed by this cycle's pop counts as free. A read started now
    // cannot return before next cycle, so the buffer cannot overflow.
    assign can_fetch = (count < FULL_CNT) || pop;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state. A started read always runs to completion.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (can_fetch && !data_req && !pc_load) state_nxt = REQ;
            REQ:     if (mem_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs. rst masks them so they are already in their reset
    // values during the reset cycle itself.
    always_comb begin
        mem_rd      = (state == REQ) && !rst;
        mem_addr    = mem_rd ? req_addr : 16'h0000;
        bus_gnt     = data_req && ((state == IDLE) || rst);
        instr_valid = (count != '0) && !rst;
        instr       = instr_valid ? fifo[rd_ptr] : 8'h00;
    end

    // Fetch PC, read address latch, discard flag and FIFO control.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_VECTOR;
            req_addr <= RESET_VECTOR;
            discard  <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            // The redirect moves pc while a read may still be in flight.
            // mem_addr comes from req_addr so it stays stable.
            if (state == IDLE && state_nxt == REQ)
                req_addr <= pc;

            if (pc_load)   pc <= pc_target;
            else if (push) pc <= pc + 16'd1;

            // A redirect in the completing cycle drops the byte directly,
            // so the flag is only needed when the read outlives the redirect.
            if (pc_load && state == REQ && !mem_ready) discard <= 1'b1;
            else if (rd_done)                          discard <= 1'b0;

            if (pc_load) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) fifo[wr_ptr] <= mem_rdata;
    end

endmodule

// File: tb/tb_ifu.sv
// Testbench for ifu. The bench has three parts:
//   - a memory model with a programmable wait latency, which checks each read
//     address against an expected-address queue;
//   - a monitor that pops the expected-instruction queue on every accepted
//     instruction;
//   - a main thread that runs a table of redirect/stream vectors and
//     hand-written multi-cycle sequences.
module tb_ifu;

`ifdef IFU_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ready = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        data_req;
    logic        bus_gnt;
    logic        pc_load;
    logic [15:0] pc_target;
    logic [7:0]  instr;
    logic        instr_valid;
    logic        instr_ready;

    ifu #(.RESET_VECTOR(16'h0100)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .data_req(data_req), .bus_gnt(bus_gnt),
        .pc_load(pc_load), .pc_target(pc_target),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] target;
        int          lat;
        int          n;
        logic [15:0] exp_last;
        int          exp_cyc;
    } vec_t;

    vec_t        vecs [5];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_addr [$];
    logic [7:0]  exp_instr [$];
    int          mem_lat = 0;
    int          wait_cnt = 0;
    int          rd_starts = 0;
    int          rd_base;
    logic        rd_prev = 1'b0;
    logic [15:0] last_addr = 16'h0000;
    logic        mem_override = 1'b0;
    logic        ovr_ready = 1'b0;
    logic [7:0]  ovr_rdata = 8'h00;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk); #1;
    endtask

    // Memory model: responds after mem_lat wait cycles; verifies read addresses.
    initial forever begin
        @(posedge clk); #2;
        if (mem_override) begin
            mem_ready = ovr_ready;
            mem_rdata = ovr_rdata;
        end else if (mem_rd) begin
            if (!rd_prev) begin
                rd_starts++;
                last_addr = mem_addr;
                if (exp_addr.size() != 0)
                    chk("rd_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
            end
            if (wait_cnt >= mem_lat) begin
                mem_ready = 1'b1;
                mem_rdata = mem_byte(mem_addr);
                wait_cnt  = 0;
            end else begin
                mem_ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end
        rd_prev = mem_rd;
    end

    // Scoreboard consumer: each accepted instruction is compared with the queue head.
    initial forever begin
        @(negedge clk);
        if (instr_valid && instr_ready && !pc_load) begin
            if (exp_instr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra got=%0h exp=none", instr);
            end else begin
                chk("sb_instr", 32'(instr), 32'(exp_instr.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Leaves the DUT idle with data_req=1 so that no fetch starts on its own.
    task automatic do_reset();
        rst = 1'b1; data_req = 1'b1; pc_load = 1'b0; instr_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        exp_addr.delete();
        exp_instr.delete();
    endtask

    // Redirect to v.target, then stream v.n bytes with instr_ready=1.
    task automatic run_vec(input vec_t v);
        int done_c;
        do_reset();
        mem_lat = v.lat;
        for (int i = 0; i < v.n; i++) begin
            exp_addr.push_back(v.target + 16'(i));
            exp_instr.push_back(mem_byte(v.target + 16'(i)));
        end
        cyc();
        data_req = 1'b0; pc_target = v.target; instr_ready = 1'b1;
        done_c = -1;
        for (int c = 0; c < 80; c++) begin
            pc_load = (c == 0);
            smp();
            if (exp_instr.size() == 0) begin
                done_c = c;
                break;
            end
            cyc();
        end
        if (done_c < 0) begin
            checks++;
            errors++;
            $display("FAIL drain got=timeout exp=%0d_bytes", v.n);
        end
        chk("last_addr", 32'(last_addr), 32'(v.exp_last));
        chk("stream_cycles", 32'(done_c), 32'(v.exp_cyc));
        cyc();
        instr_ready = 1'b0; pc_load = 1'b0;
    endtask

    initial begin
        // Cycle of the last pop, counted from the redirect: 3+L+(n-1)*(L+2)
        vecs[0] = '{16'h0040, 0, 3, 16'h0042, 7};
        vecs[1] = '{16'hFFFE, 0, 3, 16'h0000, 7};
        vecs[2] = '{16'h1234, 2, 2, 16'h1235, 9};
        vecs[3] = '{16'h8000, 1, 4, 16'h8003, 13};
        vecs[4] = '{16'hFFFF, 3, 2, 16'h0000, 11};

        rst = 1'b1; data_req = 1'b1; pc_load = 1'b0; pc_target = 16'h0000; instr_ready = 1'b0;

        // Outputs while in reset
        cyc(); smp();
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_gnt_hi", 32'(bus_gnt), 32'd1);
        cyc(); data_req = 1'b0; smp();
        chk("rst_gnt_lo", 32'(bus_gnt), 32'd0);

        // Stream from RESET_VECTOR with mem_ready always 1
        cyc(); rst = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_addr.push_back(16'h0100 + 16'(i));
            exp_instr.push_back(mem_byte(16'h0100 + 16'(i)));
        end
        smp();
        chk("c0_idle", 32'(mem_rd), 32'd0);
        cyc(); smp();
        chk("first_rd", 32'(mem_rd), 32'd1);
        chk("first_addr", 32'(mem_addr), 32'h0100);
        chk("c1_valid", 32'(instr_valid), 32'd0);
        cyc(); smp();
        chk("c2_valid", 32'(instr_valid), 32'd1);
        chk("c2_instr", 32'(instr), 32'(mem_byte(16'h0100)));
        for (int k = 0; k < 40 && exp_instr.size() != 0; k++) begin
            cyc(); smp();
        end
        chk("stream_drained", 32'(exp_instr.size()), 32'd0);
        cyc(); instr_ready = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // instr_ready held low: DEPTH reads then idle; a pop restarts fetch at once
        do_reset();
        mem_lat = 0;
        exp_addr.push_back(16'h0100);
        if (DEPTH == 2) exp_addr.push_back(16'h0101);
        rd_base = rd_starts;
        cyc(); data_req = 1'b0;
        repeat (12) cyc();
        smp();
        chk("hold_reads", 32'(rd_starts - rd_base), 32'(DEPTH));
        chk("hold_rd_off", 32'(mem_rd), 32'd0);
        chk("hold_valid", 32'(instr_valid), 32'd1);
        chk("hold_instr", 32'(instr), 32'(mem_byte(16'h0100)));
        exp_instr.push_back(mem_byte(16'h0100));
        cyc(); instr_ready = 1'b1; smp();
        cyc(); instr_ready = 1'b0; smp();
        chk("pop_sb_empty", 32'(exp_instr.size()), 32'd0);
        chk("pop_refetch_rd", 32'(mem_rd), 32'd1);
        chk("pop_refetch_addr", 32'(mem_addr), 32'(16'h0100 + 16'(DEPTH)));

        // Redirect while a slow read is in flight: the returned byte is dropped
        do_reset();
        mem_lat = 3;
        exp_addr.push_back(16'h0100);
        exp_addr.push_back(16'h0040);
        cyc(); data_req = 1'b0;
        cyc(); pc_load = 1'b1; pc_target = 16'h0040; smp();
        chk("dis_rd_d1", 32'(mem_rd), 32'd1);
        cyc(); pc_load = 1'b0; smp();
        chk("dis_hold_rd", 32'(mem_rd), 32'd1);
        chk("dis_hold_addr", 32'(mem_addr), 32'h0100);
        cyc(); cyc(); smp();
        chk("dis_ready_valid", 32'(instr_valid), 32'd0);
        cyc(); smp();
        chk("dis_drop_valid", 32'(instr_valid), 32'd0);
        chk("dis_idle_rd", 32'(mem_rd), 32'd0);
        cyc(); mem_lat = 0; smp();
        chk("redir_rd", 32'(mem_rd), 32'd1);
        chk("redir_addr", 32'(mem_addr), 32'h0040);
        cyc(); smp();
        chk("redir_valid", 32'(instr_valid), 32'd1);
        chk("redir_instr", 32'(instr), 32'(mem_byte(16'h0040)));

        // data_req during a read: the grant waits for completion
        do_reset();
        mem_lat = 2;
        cyc(); data_req = 1'b0;
        cyc(); data_req = 1'b1; smp();
        chk("dreq_gnt_e1", 32'(bus_gnt), 32'd0);
        chk("dreq_rd_e1", 32'(mem_rd), 32'd1);
        cyc(); smp();
        chk("dreq_gnt_e2", 32'(bus_gnt), 32'd0);
        cyc(); smp();
        chk("dreq_gnt_e3", 32'(bus_gnt), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(); smp();
            chk("dreq_gnt_after", 32'(bus_gnt), 32'd1);
            chk("dreq_rd_blocked", 32'(mem_rd), 32'd0);
        end
        cyc(); data_req = 1'b0; pc_load = 1'b1; pc_target = 16'h2000; smp();
        chk("flush_pre_valid", 32'(instr_valid), 32'd1);
        cyc(); pc_load = 1'b0; smp();
        chk("flush_valid", 32'(instr_valid), 32'd0);
        chk("flush_gnt", 32'(bus_gnt), 32'd0);
        cyc(); smp();
        chk("flush_rd", 32'(mem_rd), 32'd1);
        chk("flush_addr", 32'(mem_addr), 32'h2000);

        // Reset mid-read with mem_ready in the reset cycle
        do_reset();
        mem_lat = 5;
        exp_addr.push_back(16'h0100);
        exp_addr.push_back(16'h0100);
        cyc(); data_req = 1'b0;
        cyc(); smp();
        chk("rrst_rd_before", 32'(mem_rd), 32'd1);
        cyc(); rst = 1'b1; mem_override = 1'b1; ovr_ready = 1'b1; ovr_rdata = 8'hAA; smp();
        chk("rrst_rd", 32'(mem_rd), 32'd0);
        chk("rrst_gnt", 32'(bus_gnt), 32'd0);
        cyc(); rst = 1'b0; mem_override = 1'b0; ovr_ready = 1'b0; smp();
        chk("rrst_empty", 32'(instr_valid), 32'd0);
        chk("rrst_idle", 32'(mem_rd), 32'd0);
        cyc(); mem_lat = 0; smp();
        chk("rrst_refetch_rd", 32'(mem_rd), 32'd1);
        chk("rrst_refetch_addr", 32'(mem_addr), 32'h0100);
        cyc(); smp();
        chk("rrst_valid", 32'(instr_valid), 32'd1);
        chk("rrst_instr", 32'(instr), 32'(mem_byte(16'h0100)));

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
